// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encoding and request-type constants shared by the memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} mem_arb_state_t;
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick: picks one requester and returns it as one-hot grant plus index.
// Highest index wins by default; MEM_ARBITER_RR_EN searches round-robin starting after i_last.
module mem_arbiter_pick #(
    parameter int N_CLIENTS = 2,
    localparam int IW = $clog2(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] i_req,
`ifdef MEM_ARBITER_RR_EN
    input  logic [IW-1:0]        i_last,
`endif
    output logic [N_CLIENTS-1:0] o_grant,
    output logic [IW-1:0]        o_idx
);
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
`ifdef MEM_ARBITER_RR_EN
        // Scanned backwards so the first requester after i_last is the last one written
        for (int k = N_CLIENTS; k >= 1; k--)
            if (i_req[(int'(i_last) + k) % N_CLIENTS]) o_idx = IW'((int'(i_last) + k) % N_CLIENTS);
`else
        for (int k = 0; k < N_CLIENTS; k++)
            if (i_req[k]) o_idx = IW'(k);
`endif
        o_grant[o_idx] = |i_req;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port among N_CLIENTS caches, one transaction in flight.
// Fixed priority (highest index) by default; define MEM_ARBITER_RR_EN for round-robin arbitration.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_CLIENTS  = 2,
    parameter int PA_WIDTH   = 8,
    parameter int LINE_WIDTH = 64,
    localparam int IW = $clog2(N_CLIENTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_CLIENTS-1:0]                 i_cl_enable,
    input  logic [N_CLIENTS-1:0]                 i_cl_type,
    input  logic [N_CLIENTS-1:0][PA_WIDTH-1:0]   i_cl_addr,
    input  logic [N_CLIENTS-1:0][LINE_WIDTH-1:0] i_cl_data,
    input  logic [N_CLIENTS-1:0]                 i_cl_ack,
    output logic [N_CLIENTS-1:0]                 o_cl_enable,
    output logic [PA_WIDTH-1:0]                  o_cl_addr,
    output logic [LINE_WIDTH-1:0]                o_cl_data,
    output logic                                 o_mem_enable,
    output logic                                 o_mem_type,
    output logic [PA_WIDTH-1:0]                  o_mem_addr,
    output logic [LINE_WIDTH-1:0]                o_mem_data,
    output logic                                 o_mem_ack,
    input  logic                                 i_mem_enable,
    input  logic [PA_WIDTH-1:0]                  i_mem_addr,
    input  logic [LINE_WIDTH-1:0]                i_mem_data,
    output logic                                 o_busy,
    output logic [IW-1:0]                        o_owner
);
    mem_arb_state_t        r_state;
    logic [N_CLIENTS-1:0]  r_cl_enable;
    logic [PA_WIDTH-1:0]   r_mem_addr, r_rsp_addr;
    logic [LINE_WIDTH-1:0] r_mem_data, r_rsp_data;
    logic                  r_mem_enable, r_mem_type;
    logic [IW-1:0]         r_owner;
    logic [N_CLIENTS-1:0]  w_grant;
    logic [IW-1:0]         w_idx;
    logic                  w_match, w_done;
`ifdef MEM_ARBITER_RR_EN
    logic [IW-1:0]         r_last;
`endif

    mem_arbiter_pick #(.N_CLIENTS(N_CLIENTS)) u_pick (
        .i_req   (i_cl_enable),
`ifdef MEM_ARBITER_RR_EN
        .i_last  (r_last),
`endif
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_match = i_mem_enable && (i_mem_addr == r_mem_addr);
    // A client that dropped its request counts as done, so the arbiter acks memory for it
    assign w_done  = !i_cl_enable[r_owner] || i_cl_ack[r_owner];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cl_enable  <= '0;
            r_mem_addr   <= '0;
            r_rsp_addr   <= '0;
            r_mem_data   <= '0;
            r_rsp_data   <= '0;
            r_mem_enable <= 1'b0;
            r_mem_type   <= MEM_READ;
            r_owner      <= '0;
`ifdef MEM_ARBITER_RR_EN
            r_last       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (|i_cl_enable) begin
                    r_owner      <= w_idx;
                    r_mem_type   <= |(i_cl_type & w_grant);
                    r_mem_addr   <= i_cl_addr[w_idx];
                    r_mem_data   <= i_cl_data[w_idx];
                    r_mem_enable <= 1'b1;
                    r_state      <= REQ;
`ifdef MEM_ARBITER_RR_EN
                    r_last       <= w_idx;
`endif
                end
                REQ: r_state <= WAIT;
                WAIT: if (w_match) begin
                    r_rsp_addr   <= i_mem_addr;
                    r_rsp_data   <= i_mem_data;
                    r_mem_enable <= 1'b0;
                    r_cl_enable  <= i_cl_enable[r_owner] ? N_CLIENTS'(1) << r_owner : '0;
                    r_state      <= RESP;
                end
                RESP: if (w_done) begin
                    r_cl_enable <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cl_enable  = r_cl_enable;
    assign o_cl_addr    = r_rsp_addr;
    assign o_cl_data    = r_rsp_data;
    assign o_mem_enable = r_mem_enable;
    assign o_mem_type   = r_mem_type;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_mem_ack    = (r_state == RESP) && w_done;
    assign o_busy       = r_state != IDLE;
    assign o_owner      = r_owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scripted and randomized transactions against a policy-level model of mem_arbiter.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;
    localparam int N = 2, AW = 8, LW = 64;

    logic clk = 0, rst = 1;
    logic [N-1:0] cl_en, cl_type, cl_ack, o_cl_en;
    logic [N-1:0][AW-1:0] cl_addr;
    logic [N-1:0][LW-1:0] cl_data;
    logic [AW-1:0] o_cl_addr, o_mem_addr, mem_addr;
    logic [LW-1:0] o_cl_data, o_mem_data, mem_data;
    logic o_mem_en, o_mem_type, o_mem_ack, mem_en, o_busy;
    logic [$clog2(N)-1:0] o_owner;
    int total = 0, bad = 0, last = 0;

    mem_arbiter #(.N_CLIENTS(N), .PA_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_cl_enable(cl_en), .i_cl_type(cl_type), .i_cl_addr(cl_addr), .i_cl_data(cl_data), .i_cl_ack(cl_ack),
        .o_cl_enable(o_cl_en), .o_cl_addr(o_cl_addr), .o_cl_data(o_cl_data),
        .o_mem_enable(o_mem_en), .o_mem_type(o_mem_type), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_mem_ack(o_mem_ack), .i_mem_enable(mem_en), .i_mem_addr(mem_addr), .i_mem_data(mem_data),
        .o_busy(o_busy), .o_owner(o_owner)
    );

    always #5 clk = ~clk;

    // Winner by policy: highest requesting index, or first requester after the previous owner
    function automatic int model_pick(input logic [N-1:0] req, input int prev);
`ifdef MEM_ARBITER_RR_EN
        for (int k = 1; k <= N; k++) if (req[(prev + k) % N]) return (prev + k) % N;
`else
        for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
`endif
        return -1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cl_en = 0; cl_type = 0; cl_ack = 0; cl_addr = '0; cl_data = '0;
        mem_en = 0; mem_addr = 0; mem_data = 0;
        #3 rst = 0;
        #1;
        total++;
        if ({o_cl_en, o_cl_addr, o_cl_data, o_mem_en, o_mem_type, o_mem_addr, o_mem_data, o_mem_ack, o_busy, o_owner} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got cl_en=%b mem_en=%b ack=%b busy=%b owner=%0d addr=%h data=%h, want all 0", o_cl_en, o_mem_en, o_mem_ack, o_busy, o_owner, o_mem_addr, o_mem_data);
        end
        step; step;
        @(negedge clk) rst = 1;
        step;
        total++;
        if (o_busy !== 0 || o_mem_en !== 0) begin bad++; $display("FAIL reset_idle: busy=%b mem_en=%b want 0 0", o_busy, o_mem_en); end
        last = 0;
    endtask

    task automatic test_single_read;
        cl_addr[0] = 8'h0F; cl_type[0] = MEM_READ; cl_en[0] = 1;
        step;
        total++;
        if (o_mem_en !== 1 || o_mem_addr !== 8'h0F || o_mem_type !== 0 || o_owner !== 0 || o_busy !== 1) begin
            bad++; $display("FAIL single_req: en=%b addr=%h type=%b owner=%0d want 1 0f 0 0", o_mem_en, o_mem_addr, o_mem_type, o_owner);
        end
        step; step;
        mem_en = 1; mem_addr = 8'h0F; mem_data = {32'hAAAAAAAA, 32'hBBBBBBBB};
        total++;
        if (o_cl_en !== 0 || o_mem_en !== 1) begin bad++; $display("FAIL single_wait: cl_en=%b mem_en=%b want 00 1", o_cl_en, o_mem_en); end
        step;
        total++;
        if (o_cl_en !== 2'b01 || o_cl_data !== {32'hAAAAAAAA, 32'hBBBBBBBB} || o_cl_addr !== 8'h0F || o_mem_en !== 0 || o_mem_ack !== 0) begin
            bad++; $display("FAIL single_resp: cl_en=%b data=%h addr=%h mem_en=%b ack=%b want 01 aaaaaaaabbbbbbbb 0f 0 0", o_cl_en, o_cl_data, o_cl_addr, o_mem_en, o_mem_ack);
        end
        cl_ack[0] = 1;
        #1;
        total++;
        if (o_mem_ack !== 1) begin bad++; $display("FAIL single_ack: mem_ack=%b want 1", o_mem_ack); end
        step;
        total++;
        if (o_busy !== 0 || o_cl_en !== 0 || o_mem_ack !== 0) begin bad++; $display("FAIL single_done: busy=%b cl_en=%b ack=%b want 0 00 0", o_busy, o_cl_en, o_mem_ack); end
        cl_en = 0; cl_ack = 0; mem_en = 0; last = 0;
    endtask

    task automatic test_simultaneous;
        int exp;
        logic [LW-1:0] rd;
        for (int p = 0; p < 2; p++) begin
            cl_addr[0] = 8'h05; cl_type[0] = MEM_READ; cl_data[0] = 64'h1111_1111_1111_1111;
            cl_addr[1] = 8'hA0; cl_type[1] = MEM_WRITE; cl_data[1] = 64'h2222_2222_3333_3333;
            cl_en = 2'b11;
            for (int t = 0; t < 2; t++) begin
                exp = model_pick(cl_en, last);
                step;
                total++;
                if (int'(o_owner) !== exp || o_mem_addr !== cl_addr[exp] || o_mem_type !== cl_type[exp] || (cl_type[exp] && o_mem_data !== cl_data[exp])) begin
                    bad++; $display("FAIL simul_grant p%0d t%0d: owner=%0d addr=%h type=%b data=%h want owner=%0d addr=%h type=%b", p, t, o_owner, o_mem_addr, o_mem_type, o_mem_data, exp, cl_addr[exp], cl_type[exp]);
                end
                last = exp;
                step;
                rd = {$urandom, $urandom};
                mem_en = 1; mem_addr = cl_addr[exp]; mem_data = rd;
                step;
                total++;
                if (o_cl_en !== (2'b01 << exp) || o_cl_data !== rd) begin
                    bad++; $display("FAIL simul_resp p%0d t%0d: cl_en=%b data=%h want %b %h", p, t, o_cl_en, o_cl_data, 2'b01 << exp, rd);
                end
                cl_ack[exp] = 1;
                step;
                cl_en[exp] = 0; cl_ack = 0; mem_en = 0;
            end
        end
    endtask

    task automatic test_wrong_addr;
        cl_addr[0] = 8'hA4; cl_type[0] = MEM_READ; cl_en[0] = 1;
        step; step;
        mem_en = 1; mem_addr = 8'hB0; mem_data = 64'hDEAD;
        cl_ack[0] = 1;
        step; step;
        total++;
        if (o_cl_en !== 0 || o_mem_ack !== 0 || o_busy !== 1 || o_mem_en !== 1) begin
            bad++; $display("FAIL wrong_addr_ignored: cl_en=%b ack=%b busy=%b mem_en=%b want 00 0 1 1", o_cl_en, o_mem_ack, o_busy, o_mem_en);
        end
        cl_ack[0] = 0;
        mem_addr = 8'hA4; mem_data = 64'h0123_4567_89AB_CDEF;
        step;
        total++;
        if (o_cl_en !== 2'b01 || o_cl_data !== 64'h0123_4567_89AB_CDEF || o_cl_addr !== 8'hA4) begin
            bad++; $display("FAIL wrong_addr_resume: cl_en=%b data=%h addr=%h want 01 0123456789abcdef a4", o_cl_en, o_cl_data, o_cl_addr);
        end
        cl_ack[0] = 1;
        step;
        cl_en = 0; cl_ack = 0; mem_en = 0; last = 0;
    endtask

    task automatic test_abandon;
        cl_addr[1] = 8'h3C; cl_type[1] = MEM_READ; cl_en[1] = 1;
        step;
        total++;
        if (o_owner !== 1 || o_mem_addr !== 8'h3C) begin bad++; $display("FAIL abandon_grant: owner=%0d addr=%h want 1 3c", o_owner, o_mem_addr); end
        last = 1;
        step;
        cl_en[1] = 0;
        mem_en = 1; mem_addr = 8'h3C; mem_data = 64'h55;
        step;
        total++;
        if (o_cl_en !== 0 || o_mem_ack !== 1) begin bad++; $display("FAIL abandon_ack: cl_en=%b ack=%b want 00 1", o_cl_en, o_mem_ack); end
        step;
        total++;
        if (o_mem_ack !== 0 || o_busy !== 0 || o_cl_en !== 0) begin bad++; $display("FAIL abandon_idle: ack=%b busy=%b cl_en=%b want 0 0 00", o_mem_ack, o_busy, o_cl_en); end
        mem_en = 0;
    endtask

    task automatic test_reset_mid;
        cl_addr[0] = 8'h77; cl_type[0] = MEM_READ; cl_en[0] = 1;
        step; step;
        #2 rst = 0;
        #1;
        total++;
        if ({o_cl_en, o_mem_en, o_mem_ack, o_busy, o_owner} !== '0) begin
            bad++; $display("FAIL reset_mid_outputs: cl_en=%b mem_en=%b ack=%b busy=%b owner=%0d want all 0", o_cl_en, o_mem_en, o_mem_ack, o_busy, o_owner);
        end
        @(negedge clk) rst = 1;
        last = 0;
        #1;
        total++;
        if (o_busy !== 0) begin bad++; $display("FAIL reset_mid_idle: busy=%b want 0", o_busy); end
        step;
        total++;
        if (o_mem_en !== 1 || int'(o_owner) !== model_pick(2'b01, last) || o_mem_addr !== 8'h77) begin
            bad++; $display("FAIL reset_mid_regrant: mem_en=%b owner=%0d addr=%h want 1 0 77", o_mem_en, o_owner, o_mem_addr);
        end
        step;
        mem_en = 1; mem_addr = 8'h77; mem_data = 64'h77;
        step;
        cl_ack[0] = 1;
        step;
        cl_en = 0; cl_ack = 0; mem_en = 0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] hist;
        logic [AW-1:0] addrs [2];
        addrs[0] = 8'h01; addrs[1] = 8'h03;
        cl_type[0] = MEM_READ; cl_en[0] = 1;
        for (int t = 0; t < 2; t++) begin
            cl_addr[0] = addrs[t];
            step; hist[4*t] = o_busy;
            step; hist[4*t+1] = o_busy;
            mem_en = 1; mem_addr = addrs[t]; mem_data = {56'h0, addrs[t]};
            step; hist[4*t+2] = o_busy;
            total++;
            if (o_cl_en !== 2'b01 || o_cl_data !== {56'h0, addrs[t]}) begin
                bad++; $display("FAIL b2b_resp%0d: cl_en=%b data=%h want 01 %h", t, o_cl_en, o_cl_data, {56'h0, addrs[t]});
            end
            cl_ack[0] = 1;
            step; hist[4*t+3] = o_busy;
            cl_ack = 0; mem_en = 0;
        end
        cl_en = 0;
        last = 0;
        total++;
        if (hist !== 8'b0111_0111) begin bad++; $display("FAIL b2b_busy: pattern=%b want 01110111", hist); end
    endtask

    task automatic test_random;
        int exp, w, dly;
        logic ab;
        logic [LW-1:0] rd;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < N; i++)
                if (!cl_en[i] && ($urandom_range(1) == 1 || (i == N - 1 && cl_en == 0))) begin
                    cl_addr[i] = 8'($urandom); cl_type[i] = 1'($urandom); cl_data[i] = {$urandom, $urandom}; cl_en[i] = 1;
                end
            exp = model_pick(cl_en, last);
            step;
            total++;
            if (int'(o_owner) !== exp || o_mem_en !== 1 || o_mem_addr !== cl_addr[exp] || o_mem_type !== cl_type[exp] || (cl_type[exp] && o_mem_data !== cl_data[exp])) begin
                bad++; $display("FAIL rnd_grant #%0d: owner=%0d en=%b addr=%h type=%b want owner=%0d addr=%h type=%b", n, o_owner, o_mem_en, o_mem_addr, o_mem_type, exp, cl_addr[exp], cl_type[exp]);
            end
            last = exp;
            step;
            w = $urandom_range(3);
            for (int c = 0; c < w; c++) begin
                mem_en = 1'($urandom); mem_addr = cl_addr[exp] ^ 8'h80; mem_data = {$urandom, $urandom};
                step;
                total++;
                if (o_cl_en !== 0 || o_busy !== 1 || o_mem_en !== 1 || o_mem_ack !== 0) begin
                    bad++; $display("FAIL rnd_wait #%0d: cl_en=%b busy=%b mem_en=%b ack=%b want 00 1 1 0", n, o_cl_en, o_busy, o_mem_en, o_mem_ack);
                end
            end
            ab = $urandom_range(4) == 0;
            if (ab) cl_en[exp] = 0;
            rd = {$urandom, $urandom};
            mem_en = 1; mem_addr = cl_addr[exp]; mem_data = rd;
            step;
            total++;
            if (ab) begin
                if (o_cl_en !== 0 || o_mem_ack !== 1) begin bad++; $display("FAIL rnd_abandon #%0d: cl_en=%b ack=%b want 00 1", n, o_cl_en, o_mem_ack); end
            end else begin
                if (o_cl_en !== (2'b01 << exp) || o_cl_data !== rd || o_cl_addr !== cl_addr[exp] || o_mem_ack !== 0 || o_mem_en !== 0) begin
                    bad++; $display("FAIL rnd_resp #%0d: cl_en=%b data=%h addr=%h ack=%b mem_en=%b want %b %h %h 0 0", n, o_cl_en, o_cl_data, o_cl_addr, o_mem_ack, o_mem_en, 2'b01 << exp, rd, cl_addr[exp]);
                end
                dly = $urandom_range(2);
                for (int c = 0; c < dly; c++) begin
                    step;
                    total++;
                    if (o_cl_en !== (2'b01 << exp) || o_mem_ack !== 0) begin bad++; $display("FAIL rnd_hold #%0d: cl_en=%b ack=%b want %b 0", n, o_cl_en, o_mem_ack, 2'b01 << exp); end
                end
                cl_ack[exp] = 1;
                #1;
                total++;
                if (o_mem_ack !== 1) begin bad++; $display("FAIL rnd_ack #%0d: ack=%b want 1", n, o_mem_ack); end
            end
            step;
            total++;
            if (o_busy !== 0 || o_cl_en !== 0 || o_mem_ack !== 0) begin
                bad++; $display("FAIL rnd_done #%0d: busy=%b cl_en=%b ack=%b want 0 00 0", n, o_busy, o_cl_en, o_mem_ack);
            end
            cl_en[exp] = 0; cl_ack = 0; mem_en = 0;
        end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_simultaneous;
        test_wrong_addr;
        test_abandon;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single line-wide memory port among `N_CLIENTS` cache controllers (client 0 = I-cache, client 1 = D-cache in the core).
- Latches one winning request, issues it to memory, and waits for the matching response.
- Routes the response back to the owning cache, then closes the handshake toward memory.
- Exactly one memory transaction is outstanding at any time.

## Interface
- `N_CLIENTS`, 2, number of requesting caches (≥2)
- `PA_WIDTH`, 8, physical address width
- `LINE_WIDTH`, 64, cache line width in bits
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_cl_enable`  in  [N_CLIENTS]  per-client request, held until the client acks the response
- `i_cl_type`  in  [N_CLIENTS]  per-client type, 0 = line read, 1 = line write-back
- `i_cl_addr`  in  [N_CLIENTS][PA_WIDTH]  per-client line address
- `i_cl_data`  in  [N_CLIENTS][LINE_WIDTH]  per-client write-back line
- `i_cl_ack`  in  [N_CLIENTS]  client has captured its response
- `o_cl_enable`  out  [N_CLIENTS]  response valid; at most one bit set, owner only
- `o_cl_addr`  out  PA_WIDTH  response address, broadcast to all clients
- `o_cl_data`  out  LINE_WIDTH  response line, broadcast to all clients
- `o_mem_enable`, `o_mem_type`  out  1  memory request valid, and request type
- `o_mem_addr`  out  PA_WIDTH  memory request address
- `o_mem_data`  out  LINE_WIDTH  memory request write data
- `o_mem_ack`  out  1  response consumed, sent to memory
- `i_mem_enable`  in  1  memory response valid; held by memory until `o_mem_ack`
- `i_mem_addr`  in  PA_WIDTH  memory response address
- `i_mem_data`  in  LINE_WIDTH  memory response line
- `o_busy`  out  1  transaction in flight (state ≠ IDLE)
- `o_owner`  out  $clog2(N_CLIENTS)  index of the current or most recent grantee

## Operation
State machine: IDLE → REQ → WAIT → RESP → IDLE.

- **IDLE**
  - If any `i_cl_enable` is set: pick the winner, latch its index, type, address and data.
  - Set `o_mem_enable`, then go to REQ.
- **REQ** (one cycle)
  - Request is registered out to memory; go to WAIT.
- **WAIT**
  - `o_mem_enable` stays high.
  - A response is taken when `i_mem_enable` is high and `i_mem_addr` equals the latched address.
    - Capture `i_mem_addr` and `i_mem_data`.
    - Drop `o_mem_enable`.
    - Set `o_cl_enable[owner]`.
    - Go to RESP.
  - A response with a non-matching address is ignored; the arbiter stays in WAIT.
- **RESP**
  - `o_mem_ack` is combinational: `i_cl_ack[owner]` while in RESP.
  - When `i_cl_ack[owner]` is seen: clear `o_cl_enable` and return to IDLE on that edge.
- **Abandoned request**
  - Condition: `i_cl_enable[owner]` is low in WAIT or RESP.
  - The memory transaction still completes.
  - `o_cl_enable` is never raised (or is cleared) for that response.
  - The arbiter drives `o_mem_ack` for one cycle itself on the matching response, then goes to IDLE.
- **Writes** complete with a memory response exactly like reads; the response data is forwarded unchanged.
- **Non-owner requests** are held off; no state is kept for them other than the priority pointer.

## Timing
- **Reset values:**
  - All outputs 0.
  - State IDLE.
  - `o_owner` = 0.
  - Round-robin pointer = 0.
- **Reset mid-transaction:** asynchronously returns to IDLE and drops `o_mem_enable` and `o_cl_enable`; no ack is issued.
- **Request to memory:** `o_mem_enable` is high in the cycle after the client request is sampled in IDLE (1-cycle latency).
- **Response to client:** `o_cl_enable` rises in the cycle after a matching `i_mem_enable` is sampled.
- **Ack path:** `o_mem_ack` follows `i_cl_ack` in the same cycle (zero latency).
- **Back-to-back:** after RESP → IDLE, a new grant is made on the next edge.
  - Minimum transaction is 4 cycles including the zero-wait memory case.
- **Simultaneous requests in IDLE:** exactly one grant, per the arbitration policy.
- **Ack in the same cycle as `o_cl_enable` rises:** not possible; the ack is sampled only in RESP.

## Configuration
- `MEM_ARBITER_RR_EN` defined: round-robin arbitration.
  - The search starts at `(last_owner + 1) mod N_CLIENTS`.
  - The pointer updates on every grant.
- `MEM_ARBITER_RR_EN` undefined: fixed priority, highest index wins (D-cache over I-cache).
  - No pointer register exists.

## Structure
- `mem_arbiter_pkg`:
  - state enum `mem_arb_state_t` (IDLE, REQ, WAIT, RESP)
  - localparams `MEM_READ` = 1'b0, `MEM_WRITE` = 1'b1
- Sub-module `mem_arbiter_pick`:
  - Combinational request vector + pointer → one-hot grant and index.
  - Contains both policies under the macro.
- The top level holds the FSM, request and response latches, and the pointer register.

## Test plan
1. **Single read.** Client 0 reads 8'h0F; memory answers 2 cycles later with addr 8'h0F, data {32'hAAAAAAAA, 32'hBBBBBBBB}.
   - `o_mem_enable` = 1 one cycle after the request.
   - `o_cl_enable` = 2'b01 with that data.
   - The client ack produces `o_mem_ack` in the same cycle, then IDLE.
2. **Simultaneous requests.** Client 0 reads 8'h05 and client 1 writes 8'hA0 with data 64'h2222_2222_3333_3333.
   - Fixed priority: client 1 is served first (`o_mem_type` = 1, `o_mem_data` forwarded), then client 0.
   - RR from reset: client 1 first, then client 0; a repeat pair alternates.
3. **Wrong-address response.** In WAIT for 8'hA4, memory presents 8'hB0.
   - No `o_cl_enable`, no `o_mem_ack`, state stays WAIT.
   - A later response with 8'hA4 completes normally.
4. **Abandoned request.** Client 1 drops enable in WAIT; the response for its address arrives.
   - `o_cl_enable` stays 0.
   - `o_mem_ack` = 1 for one cycle, then IDLE.
5. **Reset during transaction.** `rst` = 0 asynchronously in WAIT.
   - All outputs 0 immediately; IDLE after `rst` returns high.
   - A pending client request is re-granted.
6. **Back-to-back.** Client 0 issues two reads 8'h01, 8'h03 with zero-wait memory.
   - Each completes in 4 cycles.
   - `o_busy` drops for exactly one cycle (IDLE) between them.
